// File: rtl/led_interface.sv
// Four-channel LED driver: per-channel OFF/ON/BLINK/FLASH commands over valid/ready,
// a shared blink timebase and per-channel flash timers feeding registered LED/busy outputs.
module led_interface #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned BLINK_HALF     = 12500000,
  parameter int unsigned FLASH_LEN      = 5000000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [1:0] cmd_mode,
  output logic [3:0] led_out,
  output logic [3:0] busy
);

  typedef enum logic [1:0] {
    ModeOff   = 2'b00,
    ModeOn    = 2'b01,
    ModeBlink = 2'b10,
    ModeFlash = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] FlashLen  = CNT_W'(FLASH_LEN);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic             ready_q;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             blink_wrap;

  mode_e            mode_q [4];
  mode_e            mode_d [4];
  logic [CNT_W-1:0] flash_cnt_q [4];
  logic [CNT_W-1:0] flash_cnt_d [4];

  logic [3:0]       accept;
  logic [3:0]       lit_d;
  logic [3:0]       led_q, led_d;
  logic [3:0]       busy_q, busy_d;

  assign cmd_ready = ready_q;
  assign led_out   = led_q;
  assign busy      = busy_q;

  // Free-running timebase, independent of channel modes.
  always_comb begin
    blink_wrap    = (blink_cnt_q == BlinkLast);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + CntOne;
    blink_phase_d = blink_phase_q ^ blink_wrap;
  end

  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = cmd_valid & ready_q & (cmd_ch == 2'(i));
    end
  end

  // Next channel state. An accepted command always overrides flash expiry on the same edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mode_d[i]      = mode_q[i];
      flash_cnt_d[i] = flash_cnt_q[i];
      if (accept[i]) begin
        mode_d[i]      = mode_e'(cmd_mode);
        flash_cnt_d[i] = (mode_e'(cmd_mode) == ModeFlash) ? FlashLen : '0;
      end else if (mode_q[i] == ModeFlash) begin
        if (flash_cnt_q[i] <= CntOne) begin
          mode_d[i]      = ModeOff;
          flash_cnt_d[i] = '0;
        end else begin
          flash_cnt_d[i] = flash_cnt_q[i] - CntOne;
        end
      end
    end
  end

  // Outputs are decoded from next state so a command shows up right after its accept edge.
  always_comb begin
    lit_d  = '0;
    busy_d = '0;
    for (int i = 0; i < 4; i++) begin
      unique case (mode_d[i])
        ModeOff:   lit_d[i] = 1'b0;
        ModeOn:    lit_d[i] = 1'b1;
        ModeBlink: lit_d[i] = blink_phase_d;
        ModeFlash: lit_d[i] = (flash_cnt_d[i] != '0);
        default:   lit_d[i] = 1'b0;
      endcase
      busy_d[i] = (mode_d[i] == ModeFlash) && (flash_cnt_d[i] != '0);
    end
    led_d = lit_d ^ {4{LED_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      led_q         <= {4{LED_ACTIVE_LOW}};
      busy_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        mode_q[i]      <= ModeOff;
        flash_cnt_q[i] <= '0;
      end
    end else begin
      ready_q       <= 1'b1;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      for (int i = 0; i < 4; i++) begin
        mode_q[i]      <= mode_d[i];
        flash_cnt_q[i] <= flash_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_interface.sv
// Bench for led_interface: directed scenarios plus random commands, checked against an
// arithmetic model of channel modes, flash time remaining and edges-since-reset.
module tb_led_interface;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned BLINK_HALF     = 4;
  localparam int unsigned FLASH_LEN      = 3;
  localparam bit          LED_ACTIVE_LOW = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = 2'd0;
  logic [1:0] cmd_mode = 2'd0;
  logic [3:0] led_out;
  logic [3:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode per channel, remaining lit cycles for FLASH, edges since reset release.
  int m_mode [4];
  int m_rem  [4];
  int m_n     = 0;
  bit m_ready = 1'b0;

  led_interface #(
    .CNT_W         (CNT_W),
    .BLINK_HALF    (BLINK_HALF),
    .FLASH_LEN     (FLASH_LEN),
    .LED_ACTIVE_LOW(LED_ACTIVE_LOW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_mode (cmd_mode),
    .led_out  (led_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_led();
    logic [3:0] lit;
    bit phase;
    phase = ((m_n / BLINK_HALF) % 2) == 0;
    for (int i = 0; i < 4; i++) begin
      case (m_mode[i])
        1:       lit[i] = 1'b1;
        2:       lit[i] = phase;
        3:       lit[i] = 1'b1;
        default: lit[i] = 1'b0;
      endcase
    end
    return lit ^ {4{LED_ACTIVE_LOW}};
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (m_mode[i] == 3);
    return b;
  endfunction

  task automatic drive(input bit v, input int ch, input int mode);
    cmd_valid = v;
    cmd_ch    = 2'(ch);
    cmd_mode  = 2'(mode);
  endtask

  // One clock edge; the model consumes the same inputs the DUT samples, then #1 to sample.
  task automatic step();
    bit [3:0] acc;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0;
        m_rem[i]  = 0;
      end
      m_n     = 0;
      m_ready = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) acc[i] = cmd_valid && m_ready && (int'(cmd_ch) == i);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          m_mode[i] = int'(cmd_mode);
          m_rem[i]  = (cmd_mode == 2'd3) ? FLASH_LEN : 0;
        end else if (m_mode[i] == 3) begin
          m_rem[i]--;
          if (m_rem[i] <= 0) begin
            m_rem[i]  = 0;
            m_mode[i] = 0;
          end
        end
      end
      m_n++;
      m_ready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (led_out !== 4'hF || busy !== 4'h0 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: led=%h busy=%h rdy=%b, want led=F busy=0 rdy=0",
                 c, led_out, busy, cmd_ready);
      end
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1 || led_out !== 4'hF || busy !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_release: led=%h busy=%h rdy=%b, want led=F busy=0 rdy=1",
               led_out, busy, cmd_ready);
    end
  endtask

  task automatic test_on_off();
    drive(1, 2, 1);
    step();
    n_checks++;
    if (led_out !== 4'hB) begin
      n_fail++;
      $display("FAIL on_ch2: led=%h, want B", led_out);
    end
    drive(1, 2, 0);
    step();
    n_checks++;
    if (led_out !== 4'hF) begin
      n_fail++;
      $display("FAIL off_ch2: led=%h, want F", led_out);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_blink();
    drive(1, 0, 2);
    step();
    drive(1, 1, 2);
    step();
    drive(0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (led_out !== exp_led() || led_out[0] !== led_out[1] || led_out[3:2] !== 2'b11) begin
        n_fail++;
        $display("FAIL blink cyc%0d: led=%h, want %h", c, led_out, exp_led());
      end
      step();
    end
  endtask

  task automatic test_flash();
    int lit_cnt;
    drive(1, 3, 3);
    step();
    drive(0, 0, 0);
    lit_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (led_out !== exp_led() || busy !== exp_busy() || busy[3] !== ~led_out[3]) begin
        n_fail++;
        $display("FAIL flash cyc%0d: led=%h busy=%h, want led=%h busy=%h",
                 c, led_out, busy, exp_led(), exp_busy());
      end
      if (led_out[3] === 1'b0) lit_cnt++;
      step();
    end
    n_checks++;
    if (lit_cnt != 3) begin
      n_fail++;
      $display("FAIL flash_len: lit %0d cycles, want 3", lit_cnt);
    end
    // Retrigger while the second lit cycle is showing.
    lit_cnt = 0;
    drive(1, 3, 3);
    step();
    for (int c = 0; c < 12; c++) begin
      if (c == 1) drive(1, 3, 3);
      else drive(0, 0, 0);
      if (led_out[3] === 1'b0) lit_cnt++;
      n_checks++;
      if (led_out !== exp_led() || busy !== exp_busy()) begin
        n_fail++;
        $display("FAIL reflash cyc%0d: led=%h busy=%h, want led=%h busy=%h",
                 c, led_out, busy, exp_led(), exp_busy());
      end
      step();
    end
    n_checks++;
    if (lit_cnt != 5) begin
      n_fail++;
      $display("FAIL reflash_len: lit %0d cycles, want 5", lit_cnt);
    end
  endtask

  task automatic test_abort();
    drive(1, 1, 3);
    step();
    drive(1, 1, 1);
    step();
    drive(0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if (busy[1] !== 1'b0 || led_out[1] !== 1'b0 || led_out !== exp_led()) begin
        n_fail++;
        $display("FAIL abort_on cyc%0d: led=%h busy=%h, want led[1]=0 busy[1]=0 led=%h",
                 c, led_out, busy, exp_led());
      end
      step();
    end
    // OFF arriving on the very edge the flash counter expires.
    drive(1, 1, 3);
    step();
    drive(0, 0, 0);
    step();
    step();
    drive(1, 1, 0);
    step();
    drive(0, 0, 0);
    n_checks++;
    if (busy[1] !== 1'b0 || led_out[1] !== 1'b1 || led_out !== exp_led()) begin
      n_fail++;
      $display("FAIL expiry_off: led=%h busy=%h, want led[1]=1 busy[1]=0 led=%h",
               led_out, busy, exp_led());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step();
      n_checks++;
      if (led_out !== exp_led() || busy !== exp_busy() || cmd_ready !== m_ready) begin
        n_fail++;
        $display("FAIL random cyc%0d: led=%h busy=%h rdy=%b, want led=%h busy=%h rdy=%b",
                 c, led_out, busy, cmd_ready, exp_led(), exp_busy(), m_ready);
      end
    end
    rst_n = 1'b1;
    drive(0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] want_lit;
    want_lit = 8'b1100_0011;  // bit k: ch0 lit after k-th edge following the BLINK accept
    drive(1, 0, 2);
    step();
    drive(1, 2, 3);
    step();
    drive(0, 0, 0);
    rst_n = 1'b0;
    step();
    n_checks++;
    if (led_out !== 4'hF || busy !== 4'h0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: led=%h busy=%h rdy=%b, want led=F busy=0 rdy=0",
               led_out, busy, cmd_ready);
    end
    rst_n = 1'b1;
    step();
    drive(1, 0, 2);
    step();
    drive(0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (led_out[0] !== ~want_lit[k] || led_out !== exp_led() || busy !== 4'h0) begin
        n_fail++;
        $display("FAIL blink_restart k%0d: led=%h busy=%h, want led[0]=%b led=%h busy=0",
                 k, led_out, busy, ~want_lit[k], exp_led());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_flash();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_interface.md
Name: led_interface

Overview:
- 4-channel LED indicator driver: the output-side counterpart of the debounced key input path.
- Control logic posts per-channel commands (OFF / ON / BLINK / FLASH) over a valid/ready handshake.
- The block generates the LED drive waveforms with internal timers.
- It sits between application control logic and the board LED pins, one instance per LED bank.

Parameters:
- CNT_W, 24, width of the blink and flash counters; must hold BLINK_HALF-1 and FLASH_LEN.
- BLINK_HALF, 12500000, clock cycles per blink half-period (0.25 s at 50 MHz); legal range ≥1.
- FLASH_LEN, 5000000, clock cycles a FLASH command holds the LED lit; legal range ≥1.
- LED_ACTIVE_LOW, 1, 1 means led_out is inverted (0 = lit); 0 means active-high.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_ch  in  2  target channel 0..3.
- cmd_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 FLASH.
- led_out  out  4  LED drive, registered; polarity per LED_ACTIVE_LOW.
- busy  out  4  per-channel FLASH in progress, registered.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all channel modes = OFF; logical LED state = 0.
  - led_out = {4{LED_ACTIVE_LOW}}; busy = 0; cmd_ready = 0.
  - blink counter = 0; blink_phase = 1; flash counters = 0.
- cmd_ready:
  - goes 1 at the first edge with rst_n=1 and stays 1 until the next reset.
  - The block never back-pressures after reset.
- Acceptance = cmd_valid & cmd_ready at a rising edge.
  - cmd_ch/cmd_mode are sampled at that edge.
  - New mode is visible on led_out/busy immediately after that edge (1-cycle latency from the presented command).
  - At most one command per cycle; other channels are unaffected.
- Logical LED per channel (lit=1), driven as led_out[i] = lit[i] XOR LED_ACTIVE_LOW:
  - OFF: 0.
  - ON: 1.
  - BLINK: blink_phase.
  - FLASH: 1 while the flash counter is nonzero.
- Blink timebase:
  - single shared free-running counter, 0..BLINK_HALF-1, wraps to 0.
  - blink_phase toggles on the edge where the counter wraps (value BLINK_HALF-1 → 0).
  - All BLINK channels are phase-aligned.
  - Entering BLINK does not reset the timebase: a channel entering BLINK adopts the current phase.
  - Counter runs regardless of channel modes.
- FLASH:
  - On acceptance, flash_cnt[ch] = FLASH_LEN and busy[ch] = 1; LED is lit starting the next cycle.
  - flash_cnt decrements each following edge.
  - On the edge where flash_cnt goes 1 → 0: mode becomes OFF, lit goes 0, busy goes 0.
  - Net result: the LED is lit for exactly FLASH_LEN cycles.
  - FLASH accepted while already flashing reloads FLASH_LEN (retrigger, no gap).
  - Any non-FLASH command to a flashing channel aborts it: busy=0, flash_cnt=0, new mode applies at that edge.
- Command on the same edge a flash expires on the same channel: the command wins.
- Reset mid-operation (flashing or blinking): all state returns to reset values at that edge; no residual flash.
- Illegal states: none; all 2-bit modes are defined.

Test Plan:
(Bench parameters: CNT_W=4, BLINK_HALF=4, FLASH_LEN=3, LED_ACTIVE_LOW=1.)
1. Hold rst_n=0 for 3 cycles, release → led_out=4'hF, busy=0 during reset; cmd_ready=0 in reset, 1 from the first edge after release.
2. Send ON ch2, then OFF ch2 → led_out=4'hB the cycle after the first accept; back to 4'hF the cycle after the second.
3. Send BLINK ch0 and ch1 in consecutive cycles → both bits toggle every 4 cycles, in phase; ch1 joins with the current phase; ch2/ch3 stay 1.
4. Send FLASH ch3 → led_out[3]=0 and busy[3]=1 for exactly 3 cycles, then led_out[3]=1 and busy[3]=0; re-FLASH at cycle 2 → lit for 2+3=5 cycles total.
5. Send FLASH ch1 then ON ch1 one cycle later → busy[1] drops at the ON accept and led_out[1] stays 0 indefinitely; also issue OFF ch1 on the flash-expiry edge → OFF wins, busy=0.
6. Assert rst_n=0 mid-FLASH and mid-BLINK → next cycle led_out=4'hF, busy=0, blink_phase restarts at 1 with counter 0.
